// File: rtl/sap_xbar_pkg.sv
// ============================================================================
// sap_xbar_pkg : shared types for the SAP OBI crossbar (rules, FSM, OBI structs)
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package sap_xbar_pkg;

  typedef struct packed {
    logic [31:0] start;
    logic [31:0] end_;
  } addr_rule_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sap_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } sap_obi_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_RVALID = 2'd1,
    ST_ERR_RESP    = 2'd2
  } demux_state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADC0DE0;

endpackage

`default_nettype wire

// File: rtl/sap_addr_decoder.sv
// ============================================================================
// sap_addr_decoder : combinational address-range decoder, lowest index wins
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module sap_addr_decoder
  import sap_xbar_pkg::*;
#(
  parameter int NRULES = 2,
  parameter int IDXW   = 1
) (
  input  logic [31:0]              addr_i,
  input  addr_rule_t [NRULES-1:0]  rules_i,
  output logic [IDXW-1:0]          idx_o,
  output logic                     hit_o
);

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    for (int k = NRULES - 1; k >= 0; k--) begin
      if ((addr_i >= rules_i[k].start) && (addr_i < rules_i[k].end_)) begin
        hit_o = 1'b1;
        idx_o = IDXW'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sap_obi_demux_one_to_m.sv
// ============================================================================
// sap_obi_demux_one_to_m : per-master 1-to-M OBI demux, one outstanding txn,
//                          internal error responder for unmapped addresses
// Revision               : 1.0 - initial release
// ============================================================================
`default_nettype none

module sap_obi_demux_one_to_m
  import sap_xbar_pkg::*;
#(
  parameter type obi_req_t                   = sap_obi_req_t,
  parameter type obi_resp_t                  = sap_obi_resp_t,
  parameter int  NSLAVE                      = 2,
  parameter addr_rule_t [NSLAVE-1:0] ADDR_RULES = '0,
  parameter logic [31:0] ERR_RDATA           = ERR_RDATA_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  obi_req_t                master_req_i,
  output obi_resp_t               master_resp_o,
  output obi_req_t [NSLAVE-1:0]   slave_req_o,
  input  obi_resp_t [NSLAVE-1:0]  slave_resp_i,
  output logic                    decode_err_o
);

  localparam int IDXW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;

  demux_state_e    state_q, state_d;
  logic [IDXW-1:0] sel_q, sel_d;
  logic [IDXW-1:0] dec_idx;
  logic            dec_hit;
  logic            can_accept;

  sap_addr_decoder #(
    .NRULES (NSLAVE),
    .IDXW   (IDXW)
  ) u_dec (
    .addr_i  (master_req_i.addr),
    .rules_i (ADDR_RULES),
    .idx_o   (dec_idx),
    .hit_o   (dec_hit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    master_resp_o = '0;
    decode_err_o  = 1'b0;
    can_accept    = 1'b0;
    for (int k = 0; k < NSLAVE; k++) begin
      slave_req_o[k]     = master_req_i;
      slave_req_o[k].req = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        can_accept = 1'b1;
      end
      ST_WAIT_RVALID: begin
        master_resp_o.rvalid = slave_resp_i[sel_q].rvalid;
        master_resp_o.rdata  = slave_resp_i[sel_q].rdata;
        can_accept           = slave_resp_i[sel_q].rvalid;
        if (slave_resp_i[sel_q].rvalid) state_d = ST_IDLE;
      end
      ST_ERR_RESP: begin
        master_resp_o.rvalid = 1'b1;
        master_resp_o.rdata  = ERR_RDATA;
        can_accept           = 1'b1;
        state_d              = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new request is only looked at once the previous response is done,
    // which makes the back-to-back path identical to the idle path.
    if (can_accept && master_req_i.req) begin
      if (dec_hit) begin
        slave_req_o[dec_idx].req = 1'b1;
        master_resp_o.gnt        = slave_resp_i[dec_idx].gnt;
        if (slave_resp_i[dec_idx].gnt) begin
          sel_d   = dec_idx;
          state_d = ST_WAIT_RVALID;
        end
      end else begin
        master_resp_o.gnt = 1'b1;
        decode_err_o      = 1'b1;
        state_d           = ST_ERR_RESP;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sap_obi_demux_one_to_m.sv
// ============================================================================
// tb_sap_obi_demux_one_to_m : directed scenarios plus randomized model check
// Revision                  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sap_obi_demux_one_to_m;
  import sap_xbar_pkg::*;

  localparam addr_rule_t [1:0] RULES = {{32'h1000_0000, 32'h1000_1000},
                                        {32'h0000_0000, 32'h0001_0000}};
  localparam addr_rule_t [1:0] OVL_RULES = {{32'h0000_0000, 32'h0000_2000},
                                            {32'h0000_0000, 32'h0000_1000}};
  localparam logic [31:0] ERR = 32'hBADC0DE0;

  logic clk = 1'b0;
  logic rst_n;
  sap_obi_req_t        m_req, o_req;
  sap_obi_resp_t       m_resp, o_resp;
  sap_obi_req_t  [1:0] s_req, o_sreq;
  sap_obi_resp_t [1:0] s_resp, o_sresp;
  logic derr, o_derr;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sap_obi_demux_one_to_m #(.NSLAVE(2), .ADDR_RULES(RULES), .ERR_RDATA(ERR)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .master_req_i(m_req), .master_resp_o(m_resp),
    .slave_req_o(s_req), .slave_resp_i(s_resp), .decode_err_o(derr));

  sap_obi_demux_one_to_m #(.NSLAVE(2), .ADDR_RULES(OVL_RULES), .ERR_RDATA(ERR)) u_ovl (
    .clk_i(clk), .rst_ni(rst_n), .master_req_i(o_req), .master_resp_o(o_resp),
    .slave_req_o(o_sreq), .slave_resp_i(o_sresp), .decode_err_o(o_derr));

  // Inputs change at posedge+1, outputs are sampled at posedge+3.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    m_req = '0; s_resp = '0; o_req = '0; o_sresp = '0;
  endtask

  task automatic set_req(input logic [31:0] a, input logic we);
    m_req.req = 1'b1; m_req.we = we; m_req.be = 4'hF;
    m_req.addr = a; m_req.wdata = 32'hA5A5_0000 ^ a;
  endtask

  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < 2; i++)
      if (a >= RULES[i].start && a < RULES[i].end_) return i;
    return -1;
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({m_resp.gnt, m_resp.rvalid, m_resp.rdata, s_req[0].req, s_req[1].req, derr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs gnt=%b rvalid=%b rdata=%h sreq=%b%b derr=%b required all zero",
               m_resp.gnt, m_resp.rvalid, m_resp.rdata, s_req[1].req, s_req[0].req, derr);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_read_wait();
    set_req(32'h0000_0040, 1'b0);
    for (int c = 0; c < 3; c++) begin
      s_resp[0].gnt = (c == 2);
      #2;
      checks++;
      if (m_resp.gnt !== (c == 2)) begin
        errors++; $display("FAIL read_gnt cycle %0d got %b required %b", c, m_resp.gnt, (c == 2));
      end
      checks++;
      if (s_req[0].req !== 1'b1 || s_req[1].req !== 1'b0) begin
        errors++; $display("FAIL read_sreq cycle %0d got %b%b required 01", c, s_req[1].req, s_req[0].req);
      end
      next_cycle();
    end
    clear_inputs();
    #2;
    checks++;
    if (m_resp.rvalid !== 1'b0 || s_req[0].req !== 1'b0 || s_req[1].req !== 1'b0) begin
      errors++; $display("FAIL read_wait rvalid=%b sreq=%b%b required 0 00", m_resp.rvalid, s_req[1].req, s_req[0].req);
    end
    next_cycle();
    s_resp[0].rvalid = 1'b1; s_resp[0].rdata = 32'h1234_5678;
    #2;
    checks++;
    if (m_resp.rvalid !== 1'b1 || m_resp.rdata !== 32'h1234_5678 || s_req[1].req !== 1'b0) begin
      errors++; $display("FAIL read_resp rvalid=%b rdata=%h sreq1=%b required 1 12345678 0",
                         m_resp.rvalid, m_resp.rdata, s_req[1].req);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_unmapped();
    set_req(32'h2000_0000, 1'b1);
    s_resp[0].gnt = 1'b1; s_resp[1].gnt = 1'b1;
    #2;
    checks++;
    if (m_resp.gnt !== 1'b1 || derr !== 1'b1 || s_req[0].req !== 1'b0 || s_req[1].req !== 1'b0) begin
      errors++; $display("FAIL unmapped_gnt gnt=%b derr=%b sreq=%b%b required 1 1 00",
                         m_resp.gnt, derr, s_req[1].req, s_req[0].req);
    end
    next_cycle();
    clear_inputs();
    #2;
    checks++;
    if (m_resp.rvalid !== 1'b1 || m_resp.rdata !== ERR || derr !== 1'b0 || m_resp.gnt !== 1'b0) begin
      errors++; $display("FAIL unmapped_resp rvalid=%b rdata=%h derr=%b gnt=%b required 1 %h 0 0",
                         m_resp.rvalid, m_resp.rdata, derr, m_resp.gnt, ERR);
    end
    next_cycle();
    #2;
    checks++;
    if (m_resp.rvalid !== 1'b0) begin
      errors++; $display("FAIL unmapped_after rvalid got %b required 0", m_resp.rvalid);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    set_req(32'h1000_0010, 1'b0);
    s_resp[1].gnt = 1'b1;
    next_cycle();
    set_req(32'h0000_0100, 1'b0);
    s_resp[1].gnt = 1'b0; s_resp[1].rvalid = 1'b1; s_resp[1].rdata = 32'h1111_1111;
    s_resp[0].gnt = 1'b1;
    #2;
    checks++;
    if (s_req[0].req !== 1'b1 || m_resp.gnt !== 1'b1 || m_resp.rvalid !== 1'b1 || m_resp.rdata !== 32'h1111_1111) begin
      errors++; $display("FAIL b2b_issue sreq0=%b gnt=%b rvalid=%b rdata=%h required 1 1 1 11111111",
                         s_req[0].req, m_resp.gnt, m_resp.rvalid, m_resp.rdata);
    end
    next_cycle();
    clear_inputs();
    s_resp[0].rvalid = 1'b1; s_resp[0].rdata = 32'h0000_AAAA;
    s_resp[1].rvalid = 1'b1; s_resp[1].rdata = 32'h0000_BBBB;
    #2;
    checks++;
    if (m_resp.rvalid !== 1'b1 || m_resp.rdata !== 32'h0000_AAAA) begin
      errors++; $display("FAIL b2b_sel rvalid=%b rdata=%h required 1 0000aaaa", m_resp.rvalid, m_resp.rdata);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_blocking();
    set_req(32'h0000_0040, 1'b0);
    s_resp[0].gnt = 1'b1;
    next_cycle();
    set_req(32'h1000_0004, 1'b1);
    s_resp[1].gnt = 1'b1;
    for (int c = 0; c < 2; c++) begin
      s_resp[1].rvalid = (c == 0); s_resp[1].rdata = 32'hDEAD_BEEF;
      #2;
      checks++;
      if (s_req[1].req !== 1'b0 || m_resp.gnt !== 1'b0 || m_resp.rvalid !== 1'b0) begin
        errors++; $display("FAIL block_wait cycle %0d sreq1=%b gnt=%b rvalid=%b required 0 0 0",
                           c, s_req[1].req, m_resp.gnt, m_resp.rvalid);
      end
      next_cycle();
    end
    s_resp[1].rvalid = 1'b0;
    s_resp[0].rvalid = 1'b1; s_resp[0].rdata = 32'h0BAD_F00D;
    #2;
    checks++;
    if (s_req[1].req !== 1'b1 || m_resp.gnt !== 1'b1 || m_resp.rdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL block_release sreq1=%b gnt=%b rdata=%h required 1 1 0badf00d",
                         s_req[1].req, m_resp.gnt, m_resp.rdata);
    end
    next_cycle();
    clear_inputs();
    s_resp[1].rvalid = 1'b1; s_resp[1].rdata = 32'h0000_0001;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_overlap();
    o_req.req = 1'b1; o_req.addr = 32'h0000_0100;
    o_sresp[0].gnt = 1'b1; o_sresp[1].gnt = 1'b1;
    #2;
    checks++;
    if (o_sreq[0].req !== 1'b1 || o_sreq[1].req !== 1'b0) begin
      errors++; $display("FAIL overlap_route sreq=%b%b required 01", o_sreq[1].req, o_sreq[0].req);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    set_req(32'h0000_0200, 1'b0);
    s_resp[0].gnt = 1'b1;
    next_cycle();
    clear_inputs();
    s_resp[0].rvalid = 1'b1; s_resp[0].rdata = 32'h7777_7777;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({m_resp.gnt, m_resp.rvalid, m_resp.rdata, s_req[0].req, s_req[1].req, derr} !== '0) begin
      errors++; $display("FAIL reset_mid gnt=%b rvalid=%b rdata=%h required all zero",
                         m_resp.gnt, m_resp.rvalid, m_resp.rdata);
    end
    next_cycle();
    rst_n = 1'b1;
    #2;
    checks++;
    if (m_resp.rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_late_rvalid got %b required 0", m_resp.rvalid);
    end
    next_cycle();
    clear_inputs();
    set_req(32'h1000_0000, 1'b0);
    s_resp[1].gnt = 1'b1;
    #2;
    checks++;
    if (s_req[1].req !== 1'b1 || s_req[0].req !== 1'b0 || m_resp.gnt !== 1'b1) begin
      errors++; $display("FAIL reset_fresh sreq=%b%b gnt=%b required 10 1", s_req[1].req, s_req[0].req, m_resp.gnt);
    end
    next_cycle();
    clear_inputs();
    s_resp[1].rvalid = 1'b1;
    next_cycle();
    clear_inputs();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges [6] = '{32'h0000_0000, 32'h0000_FFFF, 32'h0001_0000,
                               32'h0FFF_FFFF, 32'h1000_0FFF, 32'h1000_1000};
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 32'h0000_FFFF);
      1: return 32'h1000_0000 + $urandom_range(0, 32'h0FFF);
      2: return $urandom;
      default: return edges[$urandom_range(0, 5)];
    endcase
  endfunction

  // Reference: track which target owes the master a response (-1 none, -2 error).
  task automatic test_random();
    int owed, tgt, nxt;
    logic exp_rv, exp_gnt, exp_err, free;
    logic [31:0] exp_rd;
    logic [1:0] exp_sreq, got_sreq;
    clear_inputs();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    owed = -1;
    for (int c = 0; c < 400; c++) begin
      m_req.req = ($urandom_range(0, 9) < 6); m_req.we = $urandom_range(0, 1);
      m_req.be = 4'($urandom); m_req.addr = rand_addr(); m_req.wdata = $urandom;
      for (int s = 0; s < 2; s++) begin
        s_resp[s].gnt = $urandom_range(0, 1);
        s_resp[s].rvalid = ($urandom_range(0, 9) < 4);
        s_resp[s].rdata = $urandom;
      end
      #2;
      exp_rv = (owed == -2) ? 1'b1 : (owed >= 0) ? s_resp[owed].rvalid : 1'b0;
      exp_rd = (owed == -2) ? ERR : (owed >= 0) ? s_resp[owed].rdata : 32'h0;
      free = (owed == -1) || exp_rv;
      nxt = free ? -1 : owed;
      exp_sreq = 2'b00; exp_gnt = 1'b0; exp_err = 1'b0;
      tgt = model_decode(m_req.addr);
      if (free && m_req.req) begin
        if (tgt >= 0) begin
          exp_sreq[tgt] = 1'b1;
          exp_gnt = s_resp[tgt].gnt;
          if (exp_gnt) nxt = tgt;
        end else begin
          exp_gnt = 1'b1; exp_err = 1'b1; nxt = -2;
        end
      end
      got_sreq = {s_req[1].req, s_req[0].req};
      checks++;
      if (m_resp.gnt !== exp_gnt || m_resp.rvalid !== exp_rv || derr !== exp_err || got_sreq !== exp_sreq) begin
        errors++; $display("FAIL rand_ctrl cycle %0d gnt/rv/err/sreq=%b%b%b%b required %b%b%b%b",
                           c, m_resp.gnt, m_resp.rvalid, derr, got_sreq, exp_gnt, exp_rv, exp_err, exp_sreq);
      end
      if (exp_rv) begin
        checks++;
        if (m_resp.rdata !== exp_rd) begin
          errors++; $display("FAIL rand_rdata cycle %0d got %h required %h", c, m_resp.rdata, exp_rd);
        end
      end
      checks++;
      if (s_req[1].addr !== m_req.addr || s_req[0].wdata !== m_req.wdata ||
          s_req[1].we !== m_req.we || s_req[0].be !== m_req.be) begin
        errors++; $display("FAIL rand_bcast cycle %0d addr %h required %h", c, s_req[1].addr, m_req.addr);
      end
      owed = nxt;
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #1;
    test_reset();
    test_read_wait();
    test_unmapped();
    test_back_to_back();
    test_blocking();
    test_overlap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
